// File: rtl/progmem_arbiter.sv
// Round-robin arbiter sharing the program-memory slave port between the CPU bus (m0) and the
// loader/debug bus (m1), with a forced SLVERR completion when the slave stalls too long.
module progmem_arbiter #(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned TIMEOUT = 63
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [3:0]        m0_byteenable,
  input  logic [31:0]       m0_writedata,
  output logic [31:0]       m0_readdata,
  output logic [1:0]        m0_response,
  output logic              m0_waitrequest,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [3:0]        m1_byteenable,
  input  logic [31:0]       m1_writedata,
  output logic [31:0]       m1_readdata,
  output logic [1:0]        m1_response,
  output logic              m1_waitrequest,
  output logic [ADDR_W-1:0] s_address,
  output logic              s_read,
  output logic              s_write,
  output logic [3:0]        s_byteenable,
  output logic [31:0]       s_writedata,
  input  logic [31:0]       s_readdata,
  input  logic [1:0]        s_response,
  input  logic              s_waitrequest,
  output logic              timeout_pulse
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StGrant0, StGrant1} state_e;

  state_e          state_q, state_d;
  logic            last_grant_q, last_grant_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic              req0, req1;
  logic              granted, gnt1;
  logic              g_read, g_write, g_req;
  logic [ADDR_W-1:0] g_address;
  logic [3:0]        g_byteenable;
  logic [31:0]       g_writedata;
  logic              timeout, done;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  always_comb begin
    granted      = (state_q != StIdle);
    gnt1         = (state_q == StGrant1);
    g_read       = gnt1 ? m1_read       : m0_read;
    g_write      = gnt1 ? m1_write      : m0_write;
    g_address    = gnt1 ? m1_address    : m0_address;
    g_byteenable = gnt1 ? m1_byteenable : m0_byteenable;
    g_writedata  = gnt1 ? m1_writedata  : m0_writedata;
    g_req        = g_read | g_write;

    timeout = granted & g_req & s_waitrequest & (cnt_q == CntW'(TIMEOUT));
    done    = (granted & g_req & ~s_waitrequest) | timeout;

    s_address    = granted ? g_address    : '0;
    s_byteenable = granted ? g_byteenable : '0;
    s_writedata  = granted ? g_writedata  : '0;
    // Strobes drop on the forced-completion cycle so the slave never sees a half-finished access.
    s_read       = granted & g_read  & ~timeout;
    s_write      = granted & g_write & ~timeout;

    m0_readdata = '0;
    m0_response = '0;
    m1_readdata = '0;
    m1_response = '0;
    if (done && !gnt1) begin
      m0_readdata = timeout ? 32'h0 : s_readdata;
      m0_response = timeout ? 2'b10 : s_response;
    end
    if (done && gnt1) begin
      m1_readdata = timeout ? 32'h0 : s_readdata;
      m1_response = timeout ? 2'b10 : s_response;
    end

    m0_waitrequest = req0 & ~(done & ~gnt1);
    m1_waitrequest = req1 & ~(done & gnt1);
    timeout_pulse  = timeout;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q + CntW'(1);
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        // On contention the master that did not win last time goes first.
        if (req0 && (!req1 || last_grant_q)) begin
          state_d      = StGrant0;
          last_grant_d = 1'b0;
        end else if (req1) begin
          state_d      = StGrant1;
          last_grant_d = 1'b1;
        end
      end
      StGrant0, StGrant1: begin
        if (!g_req || done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_progmem_arbiter.sv
// Randomized bench for progmem_arbiter: transaction-level reference model, bench-side slave with
// programmable wait states, and directed transactions whose latencies are pinned by hand.
module tb_progmem_arbiter;

  localparam int unsigned ADDR_W  = 12;
  localparam int unsigned TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [ADDR_W-1:0] m0_address = '0, m1_address = '0;
  logic              m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
  logic [3:0]        m0_byteenable = '0, m1_byteenable = '0;
  logic [31:0]       m0_writedata = '0, m1_writedata = '0;
  logic [31:0]       m0_readdata, m1_readdata;
  logic [1:0]        m0_response, m1_response;
  logic              m0_waitrequest, m1_waitrequest;
  logic [ADDR_W-1:0] s_address;
  logic              s_read, s_write;
  logic [3:0]        s_byteenable;
  logic [31:0]       s_writedata;
  logic [31:0]       s_readdata = '0;
  logic [1:0]        s_response = '0;
  logic              s_waitrequest = 1'b0;
  logic              timeout_pulse;

  progmem_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
    .m0_readdata(m0_readdata), .m0_response(m0_response), .m0_waitrequest(m0_waitrequest),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
    .m1_readdata(m1_readdata), .m1_response(m1_response), .m1_waitrequest(m1_waitrequest),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_byteenable(s_byteenable), .s_writedata(s_writedata),
    .s_readdata(s_readdata), .s_response(s_response), .s_waitrequest(s_waitrequest),
    .timeout_pulse(timeout_pulse)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Bench slave: waits W cycles from the first cycle it sees a command.
  bit          rand_slave = 1'b0;
  int          dir_w = 7;
  logic [31:0] dir_rdata = 32'hDEADBEEF;
  int          s_age = 0;
  int          rnd_w = 0;

  initial forever begin
    @(negedge clk);
    if (s_read || s_write) s_age++;
    else begin
      s_age = 0;
      rnd_w = ($urandom % 8 == 0) ? 20 : int'($urandom % 12);
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    s_waitrequest = (s_age < (rand_slave ? rnd_w : dir_w));
    s_readdata    = rand_slave ? $urandom : dir_rdata;
    s_response    = rand_slave ? 2'($urandom) : 2'b00;
  end

  // Reference model: who owns the slave, for how many cycles, and who won last.
  int own  = -1;
  int age  = 0;
  int last = 1;
  bit e_done0 = 1'b0, e_done1 = 1'b0, e_greq = 1'b0;
  int n_to = 0, n_m1done = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      own  <= -1;
      age  <= 0;
      last <= 1;
    end else if (own < 0) begin
      age <= 0;
      if ((m0_read || m0_write) && (m1_read || m1_write)) begin
        own  <= 1 - last;
        last <= 1 - last;
      end else if (m0_read || m0_write) begin
        own  <= 0;
        last <= 0;
      end else if (m1_read || m1_write) begin
        own  <= 1;
        last <= 1;
      end
    end else begin
      age <= age + 1;
      if (e_done0 || e_done1 || !e_greq) own <= -1;
    end
  end

  initial begin
    bit r0, r1, g, to, nd, grd, gwr;
    logic [ADDR_W-1:0] ga;
    logic [3:0]        gbe;
    logic [31:0]       gd;
    forever begin
      @(negedge clk);
      r0 = m0_read | m0_write;
      r1 = m1_read | m1_write;
      g  = (own >= 0);
      if (own == 1) begin
        grd = m1_read; gwr = m1_write; ga = m1_address; gbe = m1_byteenable; gd = m1_writedata;
        e_greq = r1;
      end else begin
        grd = m0_read; gwr = m0_write; ga = m0_address; gbe = m0_byteenable; gd = m0_writedata;
        e_greq = r0;
      end
      if (!g) e_greq = 1'b0;
      to = e_greq && s_waitrequest && (age == int'(TIMEOUT));
      nd = e_greq && !s_waitrequest;
      e_done0 = (own == 0) && (nd || to);
      e_done1 = (own == 1) && (nd || to);
      if (timeout_pulse) n_to++;
      if (m1_read && !m1_waitrequest) n_m1done++;
      check("s_address",     32'(s_address),    g ? 32'(ga) : 32'h0);
      check("s_read",        32'(s_read),       32'(g && grd && !to));
      check("s_write",       32'(s_write),      32'(g && gwr && !to));
      check("s_byteenable",  32'(s_byteenable), g ? 32'(gbe) : 32'h0);
      check("s_writedata",   s_writedata,       g ? gd : 32'h0);
      check("timeout_pulse", 32'(timeout_pulse), 32'(to));
      check("m0_wait", 32'(m0_waitrequest), 32'(r0 && !e_done0));
      check("m1_wait", 32'(m1_waitrequest), 32'(r1 && !e_done1));
      check("m0_rdata", m0_readdata, e_done0 ? (to ? 32'h0 : s_readdata) : 32'h0);
      check("m1_rdata", m1_readdata, e_done1 ? (to ? 32'h0 : s_readdata) : 32'h0);
      check("m0_resp", 32'(m0_response), e_done0 ? (to ? 32'h2 : 32'(s_response)) : 32'h0);
      check("m1_resp", 32'(m1_response), e_done1 ? (to ? 32'h2 : 32'(s_response)) : 32'h0);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic drive(input int m, input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                       input logic [3:0] be, input logic [31:0] d);
    if (m == 0) begin
      m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = d;
    end else begin
      m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = d;
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Called at posedge+2; returns cycles from request to completion (-1 if never).
  task automatic xact(input int m, input bit wr, input logic [ADDR_W-1:0] a, input logic [3:0] be,
                      input logic [31:0] d, output int lat, output logic [31:0] rd,
                      output logic [1:0] rsp);
    bit fin = 1'b0;
    lat = -1; rd = 'x; rsp = 'x;
    drive(m, !wr, wr, a, be, d);
    for (int k = 0; k < 200 && !fin; k++) begin
      #2;
      if ((m == 0) ? !m0_waitrequest : !m1_waitrequest) begin
        fin = 1'b1;
        lat = k;
        rd  = (m == 0) ? m0_readdata : m1_readdata;
        rsp = (m == 0) ? m0_response : m1_response;
      end
      step(1);
    end
    drive(m, 1'b0, 1'b0, '0, '0, '0);
  endtask

  int lat0, lat1, to_before, m1_before;
  logic [31:0] rd0, rd1;
  logic [1:0]  rsp0, rsp1;
  bit          act[2];
  bit          dn[2];
  bit          wrr[2];
  logic [ADDR_W-1:0] ra[2];
  logic [3:0]        rbe[2];
  logic [31:0]       rwd[2];

  initial begin
    #1 rst_n = 1'b0;
    m0_read = 1'b1;
    #2;
    check("rst_m0_wait",  32'(m0_waitrequest), 32'h1);
    check("rst_m1_wait",  32'(m1_waitrequest), 32'h0);
    check("rst_s_read",   32'(s_read), 32'h0);
    check("rst_m0_rdata", m0_readdata, 32'h0);
    check("rst_tpulse",   32'(timeout_pulse), 32'h0);
    m0_read = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    step(1);

    // m0 read, 7 wait states
    dir_w = 7;
    xact(0, 1'b0, 12'h123, 4'hF, 32'h0, lat0, rd0, rsp0);
    check("rd_lat", 32'(lat0), 32'd8);
    check("rd_data", rd0, 32'hDEADBEEF);
    check("rd_resp", 32'(rsp0), 32'h0);
    #2 check("rd_s_read_after", 32'(s_read), 32'h0);
    step(1);

    // m1 write reaches the slave unchanged
    fork
      xact(1, 1'b1, 12'hFFF, 4'b0101, 32'hA5A5A5A5, lat1, rd1, rsp1);
      begin
        @(posedge clk);
        #4;
        check("wr_s_write", 32'(s_write), 32'h1);
        check("wr_s_addr",  32'(s_address), 32'hFFF);
        check("wr_s_be",    32'(s_byteenable), 32'h5);
        check("wr_s_data",  s_writedata, 32'hA5A5A5A5);
      end
    join
    check("wr_lat", 32'(lat1), 32'd8);

    // stuck slave: forced completion TIMEOUT cycles after the grant
    dir_w = 100;
    to_before = n_to;
    xact(0, 1'b0, 12'h010, 4'hF, 32'h0, lat0, rd0, rsp0);
    check("to_lat", 32'(lat0), 32'(TIMEOUT + 1));
    check("to_resp", 32'(rsp0), 32'h2);
    check("to_data", rd0, 32'h0);
    #2 check("to_pulse_count", 32'(n_to - to_before), 32'h1);
    step(1);

    // granted m1 drops its read after 3 grant cycles
    to_before = n_to;
    m1_before = n_m1done;
    drive(1, 1'b1, 1'b0, 12'h200, 4'hF, 32'h0);
    step(4);
    drive(1, 1'b0, 1'b0, '0, '0, '0);
    step(1);
    dir_w = 7;
    xact(0, 1'b0, 12'h300, 4'hF, 32'h0, lat0, rd0, rsp0);
    check("abort_next_lat", 32'(lat0), 32'd8);
    check("abort_no_to", 32'(n_to - to_before), 32'h0);
    check("abort_no_done", 32'(n_m1done - m1_before), 32'h0);

    // contention after reset, then alternation
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(1);
    fork
      xact(0, 1'b0, 12'h001, 4'hF, 32'h0, lat0, rd0, rsp0);
      xact(1, 1'b0, 12'h002, 4'hF, 32'h0, lat1, rd1, rsp1);
    join
    check("both1_m0_lat", 32'(lat0), 32'd8);
    check("both1_m1_lat", 32'(lat1), 32'd17);
    xact(0, 1'b0, 12'h003, 4'hF, 32'h0, lat0, rd0, rsp0);
    check("solo_m0_lat", 32'(lat0), 32'd8);
    fork
      xact(0, 1'b0, 12'h004, 4'hF, 32'h0, lat0, rd0, rsp0);
      xact(1, 1'b0, 12'h005, 4'hF, 32'h0, lat1, rd1, rsp1);
    join
    check("both2_m1_lat", 32'(lat1), 32'd8);
    check("both2_m0_lat", 32'(lat0), 32'd17);

    // reset in the middle of an m1 grant
    dir_w = 100;
    drive(1, 1'b1, 1'b0, 12'h055, 4'hF, 32'h0);
    step(3);
    drive(0, 1'b1, 1'b0, 12'h0AA, 4'hF, 32'h0);
    rst_n = 1'b0;
    #1 check("rst_mid_s_read", 32'(s_read), 32'h0);
    step(2);
    rst_n = 1'b1;
    step(1);
    #2;
    check("rst_mid_grant_addr", 32'(s_address), 32'h0AA);
    check("rst_mid_grant_read", 32'(s_read), 32'h1);
    step(1);
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0, '0);
    step(2);

    // random traffic against the model
    rand_slave = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      for (int n = 0; n < 2; n++) begin
        if (act[n] && dn[n]) act[n] = 1'b0;
        else if (act[n] && ($urandom % 64 == 0)) act[n] = 1'b0;
        if (!act[n] && ($urandom % 3 == 0)) begin
          act[n] = 1'b1;
          wrr[n] = 1'($urandom);
          ra[n]  = ADDR_W'($urandom);
          rbe[n] = 4'($urandom);
          rwd[n] = $urandom;
        end
        if (act[n]) drive(n, !wrr[n], wrr[n], ra[n], rbe[n], rwd[n]);
        else drive(n, 1'b0, 1'b0, '0, '0, '0);
      end
      #2;
      dn[0] = (m0_read || m0_write) && !m0_waitrequest;
      dn[1] = (m1_read || m1_write) && !m1_waitrequest;
      step(1);
    end
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0, '0);
    rand_slave = 1'b0;
    step(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/progmem_arbiter.md
# progmem_arbiter

Two-master arbiter in front of the program memory slave. It shares the single Avalon-style program-memory port between the CPU bus (m0) and a loader/debug bus (m1). Arbitration is round-robin. The arbiter guarantees one idle slave cycle between transactions and ends any transaction whose slave stalls too long with an error response. It sits between the interconnect masters and the program memory wrapper.

## Interface
- ADDR_W, 12, word address width (16 KB space)
- TIMEOUT, 63, grant cycles allowed before a forced error completion (≥2)
- clk  in  1  system clock
- rst_n  in  1  async active-low reset
- m0_address / m1_address  in  ADDR_W  master word address
- m0_read, m0_write / m1_read, m1_write  in  1  command strobes, held until completion
- m0_byteenable / m1_byteenable  in  4  write byte lanes
- m0_writedata / m1_writedata  in  32  write data
- m0_readdata / m1_readdata  out  32  read data, valid only in the completion cycle
- m0_response / m1_response  out  2  00 OKAY, 10 SLVERR (timeout), valid only in the completion cycle
- m0_waitrequest / m1_waitrequest  out  1  stall to the master
- s_address  out  ADDR_W; s_read, s_write  out  1; s_byteenable  out  4; s_writedata  out  32  slave command
- s_readdata  in  32; s_response  in  2; s_waitrequest  in  1  slave return
- timeout_pulse  out  1  one-cycle pulse on each forced completion

## Operation
- FSM states: IDLE, GRANT0, GRANT1. Reset state is IDLE, with last_grant=1 so m0 wins the first contention.
- IDLE:
  - req_n = mn_read|mn_write.
  - One requester → go to GRANTn.
  - Both requesting → grant the master not equal to last_grant.
  - Update last_grant on every grant.
- GRANTn:
  - s_* are driven from master n. The s_read/s_write strobes are gated off on a timeout cycle.
  - In all other states, s_read=s_write=0, s_address=0, s_byteenable=0, s_writedata=0.
- Normal completion: in GRANTn, (s_read|s_write) & !s_waitrequest.
  - mn_waitrequest=0.
  - mn_readdata=s_readdata; mn_response=s_response.
  - Next state IDLE.
- Timeout:
  - The grant counter clears on entry to GRANTn and increments each GRANT cycle.
  - When cnt==TIMEOUT and s_waitrequest=1, the cycle is a forced completion:
    - s_read=s_write=0;
    - mn_waitrequest=0, mn_readdata=32'h0, mn_response=2'b10;
    - timeout_pulse=1;
    - next state IDLE.
  - Counter width is $clog2(TIMEOUT+1).
- Master abort: if the granted master drops read and write before completion, no completion is signalled and the next state is IDLE.
- Waitrequest: mn_waitrequest = req_n & !(completion for master n in this cycle). Any non-granted requesting master sees 1.
- Readdata/response of a master not completing: 32'h0 / 2'b00.
- Simultaneous events: a request arriving in the completion cycle is sampled in the following IDLE cycle.

## Timing
- Reset values:
  - all s_* outputs 0; timeout_pulse 0;
  - m*_readdata 0, m*_response 0;
  - m*_waitrequest = req (combinational), so it is 1 for any request during reset.
- Reset asserted mid-transaction: the FSM goes to IDLE at once, s_read/s_write drop at once, and last_grant returns to 1.
- Request held from cycle T in IDLE:
  - GRANT and slave command from T+1;
  - with a slave taking W wait cycles, completion at T+1+W;
  - IDLE at T+2+W.
- Example: with the program memory slave, W=7, so completion is at T+8.
- The other master's pending request is granted at T+3+W. The slave therefore always sees at least one cycle with read=write=0 between commands.
- Worst-case stall for a requester: two full transactions plus 2 cycles.

## Test plan
- m0 read, addr 0x123, slave model with 7 waits returning 0xDEADBEEF → m0_waitrequest low exactly at T+8, m0_readdata=0xDEADBEEF, m0_response=00, s_read low at T+9.
- m0 and m1 both request at T=0 after reset → m0 is granted first; m1 is granted at its IDLE+1; a second simultaneous round grants m1 first, then m0 (alternation).
- m1 write, addr 0xFFF, byteenable 4'b0101, data 0xA5A5A5A5 → identical values on s_*; one idle slave cycle before the next command.
- TIMEOUT=8, slave waitrequest stuck at 1, m0 read → forced completion 8 cycles after grant with m0_response=10, m0_readdata=0, timeout_pulse high for one cycle, FSM back in IDLE.
- Granted master drops read after 3 cycles → no completion and no timeout_pulse; FSM IDLE next cycle; the other master is granted afterwards.
- rst_n pulsed low in GRANT1 mid-transaction → s_read=0 immediately; after release, with both masters requesting, m0 is granted first.
